// File: rtl/main_fsm.sv
// Multicycle main controller: fetch/decode/execute/memory/writeback sequencing
// with Moore datapath selects and an FPU start/done handshake guarded by a timeout.
module main_fsm #(
  parameter int FPU_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic       FPUDone,
  output logic       IRWrite,
  output logic       NextPC,
  output logic       AdrSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       ALUOp,
  output logic [1:0] ResultSrc,
  output logic       ResSrc,
  output logic       RegW,
  output logic       MemW,
  output logic       Branch,
  output logic       FPUStart,
  output logic       FPUErr
);

  localparam int CW = (FPU_TIMEOUT > 2) ? $clog2(FPU_TIMEOUT) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'(FPU_TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_EXECUTER, S_EXECUTEI, S_ALUWB, S_BRANCH, S_FPUEX, S_FPUWB
  } state_t;

  state_t          state, state_next;
  logic [CW-1:0]   wait_cnt;
  logic            err_set;
  logic            raw_ir_write, raw_next_pc, raw_reg_w, raw_mem_w, raw_branch;

  // Funct[4:1] belong to the ALU decoder downstream, not to this controller.
  logic funct_unused;
  assign funct_unused = &{1'b0, Funct[4:1]};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_FETCH;
      wait_cnt <= '0;
      FPUErr   <= 1'b0;
    end else begin
      state    <= state_next;
      wait_cnt <= (state == S_FPUEX) ? wait_cnt + CW'(1) : '0;
      if (err_set) FPUErr <= 1'b1;
    end
  end

  // NOTE: every combinational output gets a default before the case so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    err_set    = 1'b0;
    case (state)
      S_FETCH:    state_next = S_DECODE;
      S_DECODE: begin
        case (Op)
          2'b00:   state_next = Funct[5] ? S_EXECUTEI : S_EXECUTER;
          2'b01:   state_next = S_MEMADR;
          2'b10:   state_next = S_BRANCH;
          default: state_next = S_FPUEX;
        endcase
      end
      S_MEMADR:   state_next = Funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:    state_next = S_MEMWB;
      S_MEMWB:    state_next = S_FETCH;
      S_MEMWR:    state_next = S_FETCH;
      S_EXECUTER: state_next = S_ALUWB;
      S_EXECUTEI: state_next = S_ALUWB;
      S_ALUWB:    state_next = S_FETCH;
      S_BRANCH:   state_next = S_FETCH;
      S_FPUEX: begin
        // A done on the timeout cycle still completes normally.
        if (FPUDone) begin
          state_next = Funct[0] ? S_FETCH : S_FPUWB;
        end else if (wait_cnt == WAIT_LAST) begin
          err_set    = 1'b1;
          state_next = S_FETCH;
        end
      end
      S_FPUWB:    state_next = S_FETCH;
      default:    state_next = S_FETCH;
    endcase
  end

  always_comb begin
    raw_ir_write = 1'b0;
    raw_next_pc  = 1'b0;
    raw_reg_w    = 1'b0;
    raw_mem_w    = 1'b0;
    raw_branch   = 1'b0;
    AdrSrc       = 1'b0;
    ALUSrcA      = 2'd0;
    ALUSrcB      = 2'd0;
    ALUOp        = 1'b0;
    ResultSrc    = 2'd0;
    ResSrc       = 1'b0;
    case (state)
      S_FETCH: begin
        raw_ir_write = 1'b1;
        raw_next_pc  = 1'b1;
        ALUSrcA      = 2'd1;
        ALUSrcB      = 2'd2;
        ResultSrc    = 2'd2;
      end
      S_DECODE: begin
        ALUSrcA   = 2'd1;
        ALUSrcB   = 2'd2;
        ResultSrc = 2'd2;
      end
      S_MEMADR:   ALUSrcB = 2'd1;
      S_MEMRD:    AdrSrc  = 1'b1;
      S_MEMWB: begin
        ResultSrc = 2'd1;
        raw_reg_w = 1'b1;
      end
      S_MEMWR: begin
        AdrSrc    = 1'b1;
        raw_mem_w = 1'b1;
      end
      S_EXECUTER: ALUOp = 1'b1;
      S_EXECUTEI: begin
        ALUSrcB = 2'd1;
        ALUOp   = 1'b1;
      end
      S_ALUWB:    raw_reg_w = 1'b1;
      S_BRANCH: begin
        ALUSrcB    = 2'd1;
        ResultSrc  = 2'd2;
        raw_branch = 1'b1;
      end
      S_FPUEX:    ResSrc = 1'b1;
      S_FPUWB: begin
        ResSrc    = 1'b1;
        ResultSrc = 2'd3;
        raw_reg_w = 1'b1;
      end
      default: ;
    endcase
  end

  // Strobes are gated by reset so the FETCH state held during reset emits nothing.
  assign IRWrite  = raw_ir_write & reset;
  assign NextPC   = raw_next_pc  & reset;
  assign RegW     = raw_reg_w    & reset;
  assign MemW     = raw_mem_w    & reset;
  assign Branch   = raw_branch   & reset;
  assign FPUStart = (state == S_FPUEX) && (wait_cnt == '0) && reset;

endmodule

// File: tb/tb_main_fsm.sv
// Directed per-cycle bench for main_fsm: a vector table of {inputs, expected state
// outputs} plus hand-written timeout and reset-in-FPUEX sequences.
module tb_main_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic       FPUDone;
  logic       IRWrite, NextPC, AdrSrc, ALUOp, ResSrc, RegW, MemW, Branch, FPUStart, FPUErr;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;

  int checks   = 0;
  int failures = 0;
  int cycle    = 0;

  always #5 clk = ~clk;

  main_fsm #(.FPU_TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .FPUDone(FPUDone),
    .IRWrite(IRWrite), .NextPC(NextPC), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ResultSrc(ResultSrc), .ResSrc(ResSrc),
    .RegW(RegW), .MemW(MemW), .Branch(Branch), .FPUStart(FPUStart), .FPUErr(FPUErr)
  );

  typedef struct packed {
    logic       irw;
    logic       npc;
    logic       adr;
    logic [1:0] asa;
    logic [1:0] asb;
    logic       aluop;
    logic [1:0] rsrc;
    logic       ressrc;
    logic       regw;
    logic       memw;
    logic       branch;
    logic       start;
    logic       err;
  } out_t;

  // RST = held in reset; FX0 = first FPUEX cycle, FX = later FPUEX cycles.
  typedef enum {RST, F, D, MA, MR, MWB, MW, ER, EI, AWB, BR, FX0, FX, FWB} est_t;

  typedef struct {
    logic       rst;
    logic [1:0] op;
    logic [5:0] funct;
    logic       done;
    est_t       st;
    logic       err;
  } vec_t;

  vec_t vecs[$];

  function automatic out_t expect_out(input est_t s, input logic err);
    out_t o;
    o = '0;
    o.err = err;
    case (s)
      RST: begin o.asa = 2'd1; o.asb = 2'd2; o.rsrc = 2'd2; end
      F:   begin o.irw = 1'b1; o.npc = 1'b1; o.asa = 2'd1; o.asb = 2'd2; o.rsrc = 2'd2; end
      D:   begin o.asa = 2'd1; o.asb = 2'd2; o.rsrc = 2'd2; end
      MA:  o.asb = 2'd1;
      MR:  o.adr = 1'b1;
      MWB: begin o.rsrc = 2'd1; o.regw = 1'b1; end
      MW:  begin o.adr = 1'b1; o.memw = 1'b1; end
      ER:  o.aluop = 1'b1;
      EI:  begin o.asb = 2'd1; o.aluop = 1'b1; end
      AWB: o.regw = 1'b1;
      BR:  begin o.asb = 2'd1; o.rsrc = 2'd2; o.branch = 1'b1; end
      FX0: begin o.ressrc = 1'b1; o.start = 1'b1; end
      FX:  o.ressrc = 1'b1;
      FWB: begin o.ressrc = 1'b1; o.rsrc = 2'd3; o.regw = 1'b1; end
      default: ;
    endcase
    return o;
  endfunction

  task automatic add(input logic rst, input logic [1:0] op, input logic [5:0] funct,
                     input logic done, input est_t st, input logic err);
    vec_t v;
    v.rst = rst; v.op = op; v.funct = funct; v.done = done; v.st = st; v.err = err;
    vecs.push_back(v);
  endtask

  // One cycle: drive inputs on the falling edge, then compare the Moore outputs.
  task automatic step(input logic rst, input logic [1:0] op, input logic [5:0] funct,
                      input logic done, input est_t st, input logic err, input string name);
    out_t got, exp_o;
    @(negedge clk);
    reset   = rst;
    Op      = op;
    Funct   = funct;
    FPUDone = done;
    #1;
    cycle++;
    got   = {IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ALUOp, ResultSrc,
             ResSrc, RegW, MemW, Branch, FPUStart, FPUErr};
    exp_o = expect_out(st, err);
    checks++;
    if (got !== exp_o) begin
      failures++;
      $display("FAIL %s (%s) cycle %0d: got %b expected %b", name, st.name(), cycle, got, exp_o);
    end
  endtask

  initial begin
    reset   = 1'b0;
    Op      = 2'b00;
    Funct   = 6'b000000;
    FPUDone = 1'b0;

    // Reset, then data-processing register form.
    add(0, 2'b00, 6'b000000, 0, RST, 0);
    add(0, 2'b00, 6'b000000, 0, RST, 0);
    add(1, 2'b00, 6'b000000, 0, F,   0);
    add(1, 2'b00, 6'b000000, 0, D,   0);
    add(1, 2'b00, 6'b000000, 0, ER,  0);
    add(1, 2'b00, 6'b000000, 0, AWB, 0);
    // Load: 5 cycles.
    add(1, 2'b01, 6'b000001, 0, F,   0);
    add(1, 2'b01, 6'b000001, 0, D,   0);
    add(1, 2'b01, 6'b000001, 0, MA,  0);
    add(1, 2'b01, 6'b000001, 0, MR,  0);
    add(1, 2'b01, 6'b000001, 0, MWB, 0);
    // Store: 4 cycles.
    add(1, 2'b01, 6'b000000, 0, F,   0);
    add(1, 2'b01, 6'b000000, 0, D,   0);
    add(1, 2'b01, 6'b000000, 0, MA,  0);
    add(1, 2'b01, 6'b000000, 0, MW,  0);
    // Branch: 3 cycles.
    add(1, 2'b10, 6'b000000, 0, F,   0);
    add(1, 2'b10, 6'b000000, 0, D,   0);
    add(1, 2'b10, 6'b000000, 0, BR,  0);
    // Data-processing immediate.
    add(1, 2'b00, 6'b100000, 0, F,   0);
    add(1, 2'b00, 6'b100000, 0, D,   0);
    add(1, 2'b00, 6'b100000, 0, EI,  0);
    add(1, 2'b00, 6'b100000, 0, AWB, 0);
    // FPU with writeback, done on the 3rd FPUEX cycle: 6 cycles.
    add(1, 2'b11, 6'b000000, 0, F,   0);
    add(1, 2'b11, 6'b000000, 0, D,   0);
    add(1, 2'b11, 6'b000000, 0, FX0, 0);
    add(1, 2'b11, 6'b000000, 0, FX,  0);
    add(1, 2'b11, 6'b000000, 1, FX,  0);
    add(1, 2'b11, 6'b000000, 0, FWB, 0);
    // FPU compare, done immediately: 3 cycles, no writeback.
    add(1, 2'b11, 6'b000001, 0, F,   0);
    add(1, 2'b11, 6'b000001, 0, D,   0);
    add(1, 2'b11, 6'b000001, 1, FX0, 0);
    // Store interrupted by reset in MEMWR.
    add(1, 2'b01, 6'b000000, 0, F,   0);
    add(1, 2'b01, 6'b000000, 0, D,   0);
    add(1, 2'b01, 6'b000000, 0, MA,  0);
    add(1, 2'b01, 6'b000000, 0, MW,  0);
    add(0, 2'b01, 6'b000000, 0, RST, 0);

    // The MW vector is replaced by reset asserted mid-cycle below; drop it here
    // so the table reaches MEMWR and then is reset while still in MEMWR.
    vecs.delete(vecs.size() - 2);
    for (int i = 0; i < vecs.size(); i++)
      step(vecs[i].rst, vecs[i].op, vecs[i].funct, vecs[i].done, vecs[i].st, vecs[i].err,
           $sformatf("vec%0d", i));

    // Reset asserted while MEMWR is showing its strobes: they must drop at once.
    step(1, 2'b01, 6'b000000, 0, F,  0, "st_fetch");
    step(1, 2'b01, 6'b000000, 0, D,  0, "st_decode");
    step(1, 2'b01, 6'b000000, 0, MA, 0, "st_memadr");
    step(1, 2'b01, 6'b000000, 0, MW, 0, "st_memwr");
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({MemW, AdrSrc, RegW, IRWrite} !== 4'b0000) begin
      failures++;
      $display("FAIL async_reset_memwr: got MemW/AdrSrc/RegW/IRWrite=%b expected 0000",
               {MemW, AdrSrc, RegW, IRWrite});
    end
    step(0, 2'b11, 6'b000000, 0, RST, 0, "rst_hold");

    // Timeout: FPUDone held low for 16 FPUEX cycles.
    step(1, 2'b11, 6'b000000, 0, F,   0, "to_fetch");
    step(1, 2'b11, 6'b000000, 0, D,   0, "to_decode");
    step(1, 2'b11, 6'b000000, 0, FX0, 0, "to_fpuex1");
    for (int k = 2; k <= 16; k++)
      step(1, 2'b11, 6'b000000, 0, FX, 0, $sformatf("to_fpuex%0d", k));
    step(1, 2'b11, 6'b000000, 0, F,   1, "to_err_fetch");
    step(1, 2'b11, 6'b000000, 0, D,   1, "to_err_decode");
    step(1, 2'b11, 6'b000000, 0, FX0, 1, "to_err_fpuex1");
    step(1, 2'b11, 6'b000000, 0, FX,  1, "to_err_fpuex2");

    // Reset inside FPUEX clears the sticky error.
    step(0, 2'b11, 6'b000000, 0, RST, 0, "rst_fpuex");
    step(0, 2'b11, 6'b000000, 0, RST, 0, "rst_fpuex_hold");

    // Done coinciding with the 16th FPUEX cycle wins over the timeout.
    step(1, 2'b11, 6'b000000, 0, F,   0, "edge_fetch");
    step(1, 2'b11, 6'b000000, 0, D,   0, "edge_decode");
    step(1, 2'b11, 6'b000000, 0, FX0, 0, "edge_fpuex1");
    for (int k = 2; k <= 15; k++)
      step(1, 2'b11, 6'b000000, 0, FX, 0, $sformatf("edge_fpuex%0d", k));
    step(1, 2'b11, 6'b000000, 1, FX,  0, "edge_fpuex16");
    step(1, 2'b00, 6'b000000, 0, FWB, 0, "edge_fpuwb");
    step(1, 2'b00, 6'b000000, 0, F,   0, "edge_next_fetch");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/main_fsm.md
# main_fsm

Multicycle main controller for the ARM-subset datapath with FPU extension. Sequences each instruction through fetch, decode, execute, memory and writeback states. Produces the per-cycle datapath selects and the unconditioned write strobes (RegW, MemW, Branch, ResSrc) consumed by condition/flag logic downstream. Runs an FPU start/done handshake with a cycle timeout.

## Interface
- FPU_TIMEOUT, 16: max cycles spent in FPUEX waiting for FPUDone (≥2)
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low (asserted when 0)
- Op  in  2  instruction class: 00 data-processing, 01 memory, 10 branch, 11 FPU
- Funct  in  6  instruction funct field; Funct[5] = I (immediate), Funct[0] = L (load) for memory / no-writeback (compare) for FPU
- FPUDone  in  1  FPU result valid, sampled in FPUEX
- IRWrite  out  1  instruction register enable
- NextPC  out  1  unconditional PC update
- AdrSrc  out  1  0 = PC, 1 = ALU result as memory address
- ALUSrcA  out  2  0 = Rn, 1 = PC
- ALUSrcB  out  2  0 = Rm, 1 = ExtImm, 2 = constant 4
- ALUOp  out  1  1 = decode Funct for ALU control, 0 = add
- ResultSrc  out  2  0 = ALUOut, 1 = read data, 2 = ALU direct, 3 = FPU result
- ResSrc  out  1  selects FPU flags/FlagW path downstream
- RegW  out  1  register write request (unconditioned)
- MemW  out  1  memory write request (unconditioned)
- Branch  out  1  branch request (unconditioned)
- FPUStart  out  1  one-cycle FPU launch pulse
- FPUErr  out  1  sticky FPU timeout flag

## Operation
- 4-bit state register: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTER, EXECUTEI, ALUWB, BRANCH, FPUEX, FPUWB. Moore outputs. Unlisted outputs are 0.
- FETCH: IRWrite=1, NextPC=1, AdrSrc=0, ALUSrcA=1, ALUSrcB=2, ResultSrc=2 → DECODE.
- DECODE: ALUSrcA=1, ALUSrcB=2, ResultSrc=2. Op 01 → MEMADR. Op 00 → EXECUTEI if Funct[5], else EXECUTER. Op 10 → BRANCH. Op 11 → FPUEX.
- MEMADR: ALUSrcA=0, ALUSrcB=1 → MEMRD if Funct[0], else MEMWR.
- MEMRD: AdrSrc=1 → MEMWB.
- MEMWB: ResultSrc=1, RegW=1 → FETCH.
- MEMWR: AdrSrc=1, MemW=1 → FETCH.
- EXECUTER: ALUSrcB=0, ALUOp=1 → ALUWB.
- EXECUTEI: ALUSrcB=1, ALUOp=1 → ALUWB.
- ALUWB: RegW=1 → FETCH.
- BRANCH: ALUSrcB=1, ResultSrc=2, Branch=1 → FETCH.
- FPUEX: ResSrc=1. FPUStart=1 only on the first cycle after entry. Wait counter cleared on entry and incremented each FPUEX cycle.
  - FPUDone=1 → FPUWB if Funct[0]=0, else FETCH (compare: flags only).
  - FPUDone=0 with counter = FPU_TIMEOUT-1 → set FPUErr, go to FETCH.
  - FPUDone wins if it coincides with the timeout cycle.
- FPUWB: ResSrc=1, ResultSrc=3, RegW=1 → FETCH.
- FPUErr stays set until reset.
- Op and Funct are sampled only in DECODE, MEMADR and FPUEX, where the instruction register already holds them.

## Timing
- Reset (asynchronous, reset=0):
  - state=FETCH, counter=0, FPUErr=0.
  - IRWrite, NextPC, RegW, MemW, Branch, FPUStart are forced 0 while reset=0. Selects show FETCH values.
- First FETCH strobe occurs in the first cycle after reset deasserts.
- Instruction latency in cycles, FETCH inclusive:
  - branch 3; data-processing 4; store 4; load 5.
  - FPU with writeback: 4 + k, where k = FPUEX wait cycles beyond the first.
  - FPU compare: 3 + k.
- FPUStart asserts exactly once per FPU instruction, never during a FPUEX re-entry stall.
- Reset mid-instruction: returns to FETCH immediately with no residual strobes. FPUErr clears.

## Test plan
- Reset pulse low for 2 cycles, then release, Op=00, Funct=6'b000000 → FETCH, DECODE, EXECUTER, ALUWB. RegW=1 only in the 4th cycle. IRWrite=1 only in the 1st.
- Op=01, Funct[0]=1 then Funct[0]=0 → load shows RegW=1, ResultSrc=1 in cycle 5. Store shows MemW=1, AdrSrc=1 in cycle 4, RegW never set.
- Op=10 → Branch=1 in cycle 3, then FETCH. Op=00 with Funct[5]=1 → EXECUTEI with ALUSrcB=1.
- Op=11, Funct[0]=0, FPUDone rises on 3rd FPUEX cycle → FPUStart high exactly 1 cycle. FPUWB follows with ResultSrc=3, RegW=1, ResSrc=1. Total 6 cycles.
- Op=11, FPUDone held 0, FPU_TIMEOUT=16 → 16 FPUEX cycles, then FETCH with FPUErr=1 held. Repeat with FPUDone=1 on cycle 16 → FPUWB, FPUErr stays 0.
- Assert reset in MEMWR and in FPUEX → strobes drop to 0 asynchronously, FPUErr=0. FETCH follows release.
